// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg
// Shared types and constants for the I2S receive path.
//   i2s_rx_state_e : framing FSM states (SEEK / LEFT / RIGHT)
//   i2s_chan_e     : channel a WS level belongs to
//   SYNC_STAGES    : flop depth of the input synchronizers
//   ws_to_chan()   : maps a WS level to a channel for a given WS polarity
// ---------------------------------------------------------------------------
package i2s_pkg;

    typedef enum logic [1:0] {
        SEEK  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_rx_state_e;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } i2s_chan_e;

    localparam int SYNC_STAGES = 2;

    function automatic i2s_chan_e ws_to_chan(input logic ws, input logic ws_pol);
        return (ws == ws_pol) ? CH_LEFT : CH_RIGHT;
    endfunction

endpackage

// File: rtl/i2s_rx_sync.sv
// ---------------------------------------------------------------------------
// i2s_rx_sync
// Brings the asynchronous SCK/WS/SD pins into the clk_i domain through
// equal-depth flop chains and flags SCK rising edges. Because all three pins
// travel the same number of stages, WS and SD stay aligned with SCK.
// Ports:
//   clk_i, rst_ni        : system clock, async active-low reset
//   sck_i, ws_i, sd_i    : raw I2S pins
//   sck_rise             : one-cycle flag, synchronized SCK went 0 -> 1
//   ws_s, sd_s           : synchronized WS and SD
// ---------------------------------------------------------------------------
module i2s_rx_sync
    import i2s_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sck_i,
    input  logic ws_i,
    input  logic sd_i,
    output logic sck_rise,
    output logic ws_s,
    output logic sd_s
);

    // bit 0 = sck, bit 1 = ws, bit 2 = sd
    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic                        sck_prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q     <= '0;
            sck_prev_q <= 1'b0;
        end else begin
            sync_q[0] <= {sd_i, ws_i, sck_i};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            sck_prev_q <= sync_q[SYNC_STAGES-1][0];
        end
    end

    assign sck_rise = sync_q[SYNC_STAGES-1][0] & ~sck_prev_q;
    assign ws_s     = sync_q[SYNC_STAGES-1][1];
    assign sd_s     = sync_q[SYNC_STAGES-1][2];

endmodule

// File: rtl/i2s_rx.sv
// ---------------------------------------------------------------------------
// i2s_rx
// Philips-I2S receive deserializer. Samples SCK/WS/SD in the clk_i domain,
// rebuilds left/right PCM words (MSB first, MSB one SCK after each WS edge)
// and presents completed stereo pairs on a valid/ready stream.
//
// state | meaning
// ------+--------------------------------------------------------------
// SEEK  | not aligned; data ignored until WS moves to the left level
// LEFT  | capturing a left slot; completed word goes to left_hold_q
// RIGHT | capturing a right slot; completed word loads the output pair
//
// Parameters: SAMPLE_BITS (bits kept per channel), SLOT_BITS (SCKs per
//             slot), WS_POL (WS level of the left channel).
// Ports:
//   clk_i, rst_ni        : system clock, async active-low reset
//   sck_i, ws_i, sd_i    : I2S pins, asynchronous to clk_i
//   left_o, right_o      : output pair, MSB-aligned raw words
//   valid_o / ready_i    : output handshake
//   overrun_o            : pulse, completed pair dropped (output was full)
//   sync_err_o           : pulse, slot ended before its word was complete
//   overrun_cnt_o        : saturating overrun count, only when
//                          I2S_RX_OVERRUN_CNT_EN is defined
// ---------------------------------------------------------------------------
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int   SAMPLE_BITS = 24,
    parameter int   SLOT_BITS   = 32,
    parameter logic WS_POL      = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   sck_i,
    input  logic                   ws_i,
    input  logic                   sd_i,
    output logic [SAMPLE_BITS-1:0] left_o,
    output logic [SAMPLE_BITS-1:0] right_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   overrun_o,
    output logic                   sync_err_o
`ifdef I2S_RX_OVERRUN_CNT_EN
    ,
    output logic [15:0]            overrun_cnt_o
`endif
);

    localparam int                CNT_W      = $clog2(SLOT_BITS + 1);
    localparam logic [CNT_W-1:0]  CNT_SAT    = CNT_W'(SLOT_BITS);
    localparam logic [CNT_W-1:0]  CNT_SAMPLE = CNT_W'(SAMPLE_BITS);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(SAMPLE_BITS - 1);

    logic sck_rise;
    logic ws_s;
    logic sd_s;

    i2s_rx_sync u_sync (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .sck_i    (sck_i),
        .ws_i     (ws_i),
        .sd_i     (sd_i),
        .sck_rise (sck_rise),
        .ws_s     (ws_s),
        .sd_s     (sd_s)
    );

    i2s_rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]         cnt_q;
    logic                     ws_prev_q;
    logic [SAMPLE_BITS-1:0]   shreg_q;
    logic [SAMPLE_BITS-1:0]   shreg_next;
    logic [SAMPLE_BITS-1:0]   left_hold_q;
    logic                     done_q;
    logic                     pair_pend_q;
    logic                     short_q;

    logic boundary;
    logic into_left;
    logic shift_en;
    logic word_done;
    logic left_latch;
    logic pair_load;
    logic slot_short;

    // One shift register serves both channels: every slot restarts at
    // cnt = 0 and shifts exactly SAMPLE_BITS bits before its word is
    // complete, so the previous channel's bits are always flushed out.
    generate
        if (SAMPLE_BITS > 1) begin : g_shift_multi
            assign shreg_next = {shreg_q[SAMPLE_BITS-2:0], sd_s};
        end else begin : g_shift_single
            assign shreg_next = sd_s;
        end
    endgenerate

    assign boundary  = sck_rise & (ws_s != ws_prev_q);
    assign into_left = (ws_to_chan(ws_s, WS_POL) == CH_LEFT);
    assign shift_en  = sck_rise & (cnt_q < CNT_SAMPLE);
    assign word_done = sck_rise & (cnt_q == CNT_LAST);

    // ---- FSM: state register ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SEEK;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- FSM: next state ----
    always_comb begin
        state_d = state_q;
        if (boundary) begin
            case (state_q)
                SEEK:        state_d = into_left ? LEFT : SEEK;
                LEFT, RIGHT: begin
                    // A short slot drops alignment, but a boundary into left
                    // is already a valid start, so that slot is not wasted.
                    if (into_left)       state_d = LEFT;
                    else if (slot_short) state_d = SEEK;
                    else                 state_d = RIGHT;
                end
                default:     state_d = SEEK;
            endcase
        end
    end

    // ---- FSM: outputs ----
    always_comb begin
        left_latch = 1'b0;
        pair_load  = 1'b0;
        slot_short = 1'b0;
        case (state_q)
            LEFT: begin
                left_latch = word_done;
                slot_short = boundary & ~done_q & ~word_done;
            end
            RIGHT: begin
                pair_load  = word_done;
                slot_short = boundary & ~done_q & ~word_done;
            end
            default: ;
        endcase
    end

    // ---- slot datapath ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            ws_prev_q   <= 1'b0;
            shreg_q     <= '0;
            left_hold_q <= '0;
            done_q      <= 1'b0;
            pair_pend_q <= 1'b0;
            short_q     <= 1'b0;
        end else begin
            if (sck_rise) begin
                if (boundary) begin
                    cnt_q     <= '0;
                    ws_prev_q <= ws_s;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
            if (shift_en) begin
                shreg_q <= shreg_next;
            end
            if (boundary) begin
                done_q <= 1'b0;
            end else if (word_done) begin
                done_q <= 1'b1;
            end
            if (left_latch) begin
                left_hold_q <= shreg_next;
            end
            // Registered events: the right word sits in shreg_q until the
            // next SCK rise, which is several clk_i cycles away.
            pair_pend_q <= pair_load;
            short_q     <= slot_short;
        end
    end

    // ---- output register ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            left_o     <= '0;
            right_o    <= '0;
            valid_o    <= 1'b0;
            overrun_o  <= 1'b0;
            sync_err_o <= 1'b0;
        end else begin
            overrun_o  <= 1'b0;
            sync_err_o <= short_q;
            if (pair_pend_q) begin
                if (valid_o & ~ready_i) begin
                    overrun_o <= 1'b1;
                end else begin
                    left_o  <= left_hold_q;
                    right_o <= shreg_q;
                    valid_o <= 1'b1;
                end
            end else if (ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

`ifdef I2S_RX_OVERRUN_CNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overrun_cnt_o <= '0;
        end else if (pair_pend_q & valid_o & ~ready_i & (overrun_cnt_o != 16'hFFFF)) begin
            overrun_cnt_o <= overrun_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: doc/i2s_rx.md
# i2s_rx

Receive-side I2S deserializer: samples externally supplied SCK/WS/SD pins in the `clk_i` domain and reassembles left/right PCM words. Completed stereo pairs leave on a valid/ready stream to the audio datapath. It pairs with the I2S clock generator on the transmit side of the link: same WS polarity convention, same SCK-per-slot framing, and MSB one SCK after each WS transition (Philips I2S).

## Interface
Parameters:
- `SAMPLE_BITS`, 24: bits captured per channel, MSB first; range 1..`SLOT_BITS`.
- `SLOT_BITS`, 32: SCK periods per channel slot. Frame = 2×`SLOT_BITS`.
- `WS_POL`, 1'b0: WS level of the left channel. 0 = left-low, 1 = left-high.

Ports:
- `clk_i`, in, 1: system clock, 27 MHz nominal.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `sck_i`, in, 1: I2S bit clock. Asynchronous to `clk_i`.
- `ws_i`, in, 1: I2S word select. Asynchronous.
- `sd_i`, in, 1: I2S serial data. Asynchronous.
- `left_o`, out, `SAMPLE_BITS`: left word, MSB-aligned, raw (no sign extension).
- `right_o`, out, `SAMPLE_BITS`: right word.
- `valid_o`, out, 1: pair available.
- `ready_i`, in, 1: sink accepts the pair.
- `overrun_o`, out, 1: one-cycle pulse when a completed pair is dropped.
- `sync_err_o`, out, 1: one-cycle pulse when a slot is discarded as short.
- `overrun_cnt_o`, out, 16: saturating overrun count. Present only with the macro in Configuration.

## Operation
- Synchronization: `sck_i`, `ws_i` and `sd_i` each pass through a 2-FF synchronizer. SCK rising-edge detect is `sck_s & ~sck_prev`. All capture happens on detected rising edges only.
- On each detected rising edge:
  - The sampled `sd` bit belongs to the channel of `ws_prev`, the WS value sampled at the previous rising edge.
  - The bit index `cnt` increments by 1 per edge, saturating at `SLOT_BITS`.
  - If `cnt < SAMPLE_BITS`, shift the bit into that channel's shift register.
  - When the bit at `cnt == SAMPLE_BITS-1` is shifted in, that channel's word is complete.
- Boundary: a rising edge where `ws_s != ws_prev`. The bit on this edge still belongs to the old channel (the LSB slot position). Then `cnt <= 0` and `ws_prev <= ws_s`.
- FSM, state encoding `SEEK` / `LEFT` / `RIGHT`:
  - Reset → `SEEK`.
  - `SEEK`: ignore all data. A boundary into the left level → `LEFT`.
  - `LEFT`: left word complete → latch `left_hold`. A boundary into right → `RIGHT`.
  - `RIGHT`: right word complete → load the output pair from (`left_hold`, right word). A boundary into left → `LEFT`.
- Short slot: a boundary arrives in `LEFT` or `RIGHT` before that channel's word is complete.
  - Pulse `sync_err_o`, discard the partial word, and go to `SEEK`.
  - The boundary still updates `ws_prev` and `cnt`. If it was into left, enter `LEFT` directly, so the next left slot is captured.
- Long slot (`cnt` reaches `SLOT_BITS`): extra bits are ignored. No error.
- Output register:
  - Transfer occurs when `valid_o & ready_i`.
  - Loading a pair sets `valid_o`. `left_o`/`right_o` hold stable while `valid_o & ~ready_i`.
  - Load while the output is empty, or in the same cycle as a transfer: accepted, `valid_o` stays 1.
  - Load while `valid_o & ~ready_i`: the new pair is dropped, the old pair is kept, `overrun_o` pulses.

## Timing
- Reset values:
  - `left_o`, `right_o`: 0.
  - `valid_o`, `overrun_o`, `sync_err_o`: 0.
  - `overrun_cnt_o`: 0.
  - FSM: `SEEK`. `cnt`, shift registers, `ws_prev`, synchronizers: 0.
- Reset mid-frame clears everything immediately (asynchronously). Capture resumes only after a new boundary into left.
- Latency: if a `sck_i` rise carrying right bit `SAMPLE_BITS-1` is first sampled at clk edge N:
  - N+1: in sync stage 2.
  - N+2: shift.
  - N+3: `valid_o` = 1 and data valid.
- Same N+3 rule applies to `overrun_o` and `sync_err_o`.
- Input constraint: each SCK phase ≥ 2 `clk_i` periods. The nominal 4/4 split is guaranteed correct.
- WS and SD must be stable around the SCK rise. Synchronizer skew is tolerated because all three inputs use equal-depth paths.

## Configuration
- `I2S_RX_OVERRUN_CNT_EN` defined:
  - `overrun_cnt_o` exists.
  - Increments on every `overrun_o` pulse and saturates at 16'hFFFF.
  - Clears only on reset.
- Undefined: the port and counter are absent. `overrun_o` is unaffected.

## Structure
- Package `i2s_pkg`:
  - `i2s_rx_state_e` (`SEEK`/`LEFT`/`RIGHT`).
  - `i2s_chan_e` (`CH_LEFT`/`CH_RIGHT`).
  - Shared `SYNC_STAGES = 2` localparam.
- Sub-module `i2s_rx_sync`: 3-bit 2-FF synchronizer plus SCK rising-edge detect, with outputs `sck_rise`, `ws_s`, `sd_s`.

## Test plan
Defaults throughout (`SAMPLE_BITS=24`, `SLOT_BITS=32`), SCK 4 clk high / 4 clk low.
- Nominal pair: L=0xA5A5A5, R=0x123456, `ready_i`=1 → `valid_o` asserts at N+3 with those exact values; no error pulses.
- Backpressure: `ready_i`=0 across two frames → first pair held stable; one `overrun_o` pulse; `overrun_cnt_o`=1 with the macro defined; raising `ready_i` transfers the first pair.
- Mid-stream start: release reset in the middle of a right slot → first output is the first full L/R pair; the partial slot produces no output and no `sync_err_o`.
- Short slot: WS toggles after 10 bits of a left slot → `sync_err_o` pulses once, no pair emitted, the next full frame is delivered correctly.
- Reset mid-left-slot: assert `rst_ni` low for 3 clk → all outputs 0 immediately; the next full frame is captured correctly.
- Polarity: `WS_POL`=1, L=0xFFFFFF, R=0x000001 → channels not swapped.
